flex_counter: RTL and testbench
===============================

FLEX_COUNTER -- requirements
Module: flex_counter

Interface
REQ-001 Parameter NUM_CNT_BITS, default 4, counter and rollover_val width in bits (legal range 1..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, synchronous, active-high (asserted = 1, despite the name); sampled on rising clk.
REQ-004 clear  input  1  synchronous clear, active-high.
REQ-005 count_enable  input  1  increment enable, active-high.
REQ-006 rollover_val  input  NUM_CNT_BITS  terminal count value, unsigned; sampled every cycle, not latched.
REQ-007 count_out  output  NUM_CNT_BITS  current count, driven directly from a register.
REQ-008 rollover_flag  output  1  high while count_out equals rollover_val; driven directly from a register.

Function
REQ-009 Each rising edge applies this priority: n_rst, then clear, then count_enable, then hold.
REQ-010 Clear (clear=1, n_rst=0): next count_out = 0; next rollover_flag = 0; count_enable ignored.
REQ-011 Hold (clear=0, count_enable=0): count_out and rollover_flag keep their values.
REQ-012 Count (clear=0, count_enable=1, count_out != rollover_val): next count_out = count_out + 1, modulo 2^NUM_CNT_BITS.
REQ-013 Rollover (clear=0, count_enable=1, count_out == rollover_val, rollover_val != 0): next count_out = 1.
REQ-014 Rollover sequence for rollover_val = R (R >= 1), starting from 0: 0, 1, ..., R, 1, ..., R, 1, ...; 0 is reached only through reset, clear or natural wrap.
REQ-015 rollover_val = 0: count_out counts up from its current value, wraps through 2^NUM_CNT_BITS-1 to 0, and holds at 0 while enabled; rollover_flag = 1 whenever count_out = 0 and clear = 0.
REQ-016 rollover_flag is registered: next rollover_flag = (next count_out == rollover_val). With rollover_val held stable, the flag rises in the same cycle count_out reaches R.
REQ-017 If rollover_val changes, rollover_flag is re-evaluated at the next edge, even while holding.
REQ-018 If rollover_val is lowered below count_out, counting continues upward, wraps to 0 at 2^NUM_CNT_BITS, then continues normally; rollover_val is never forced into count_out.
REQ-019 Outputs change only after rising clk edges, with no combinational path from inputs to outputs.

Reset
REQ-020 n_rst=1 at a rising edge: count_out = 0 and rollover_flag = 0, overriding clear and count_enable.
REQ-021 Reset asserted in the middle of counting or rollover discards state; counting restarts from 0 on the first enabled edge after release.
REQ-022 Before the first reset edge, outputs are unspecified; the bench applies reset before any check.

Configuration
REQ-023 Macro FLEX_COUNTER_ROLL_PULSE_EN defined: adds 1-bit registered output rollover_pulse, high for exactly one cycle after each edge where the REQ-013 rollover transition occurs; cleared by reset and clear.
REQ-024 Macro FLEX_COUNTER_ROLL_PULSE_EN undefined: rollover_pulse port and its logic are absent; all other behaviour is identical.

Verification
REQ-025 Reset: n_rst=1 for 2 edges with count_enable=1 -> count_out=0, rollover_flag=0 throughout and after release.
REQ-026 Non-power-of-2 rollover: R=3, enable for 3 edges, then disable for 2 -> count_out=3, rollover_flag=1 held.
REQ-027 Partial count: R=3, enable for 2 edges -> count_out=2, rollover_flag=0; R=4, enable for 5 edges -> count_out=1, rollover_flag=0 (wrapped once, flag high only during the cycle at 4).
REQ-028 Discontinuous: R=4, enable 2 edges, disable 2 edges, enable 2 edges -> count_out=4, rollover_flag=1; values 0,1,2,2,2,3,4.
REQ-029 Clear priority: R=4, count to 1, then clear=1 with count_enable=1 for 1 edge -> count_out=0, rollover_flag=0; clear=1 with n_rst=1 -> reset result.
REQ-030 Wrap and edge cases: NUM_CNT_BITS=4, R=0 from 0 -> holds 0 with flag 1; R=15 -> 0..15 then 1; with the macro defined, rollover_pulse is high exactly one cycle per 15->1 transition.

Source files
------------

// File: rtl/flex_counter.sv
// Up-counter with programmable terminal value; optional FLEX_COUNTER_ROLL_PULSE_EN adds a one-cycle rollover pulse.
// Outputs are registered, so changes appear one edge after the inputs; there is no backpressure, and the counter advances on every enabled edge.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
`ifdef FLEX_COUNTER_ROLL_PULSE_EN
  ,
  output logic                    rollover_pulse
`endif
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic                    r_flag;
  logic [NUM_CNT_BITS-1:0] w_next_count;
  logic                    w_at_term;
  logic                    w_rv_zero;

  assign w_at_term = (r_count == rollover_val);
  assign w_rv_zero = (rollover_val == '0);

  // A zero terminal value parks the counter at 0 instead of restarting at 1.
  always_comb begin
    w_next_count = r_count;
    if (clear) begin
      w_next_count = '0;
    end else if (count_enable) begin
      if (w_at_term) begin
        if (!w_rv_zero) begin
          w_next_count = NUM_CNT_BITS'(1);
        end
      end else begin
        w_next_count = r_count + NUM_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_flag  <= !clear && (w_next_count == rollover_val);
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_flag;

`ifdef FLEX_COUNTER_ROLL_PULSE_EN
  logic r_pulse;
  logic w_roll;

  assign w_roll = count_enable && !clear && w_at_term && !w_rv_zero;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_roll;
    end
  end

  assign rollover_pulse = r_pulse;
`endif

endmodule

// File: tb/tb_flex_counter.sv
// Directed bench for flex_counter (NUM_CNT_BITS=4) with hand-computed expectations.
module tb_flex_counter;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       count_enable;
  logic [3:0] rollover_val;
  logic [3:0] count_out;
  logic       rollover_flag;
`ifdef FLEX_COUNTER_ROLL_PULSE_EN
  logic       rollover_pulse;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  flex_counter #(.NUM_CNT_BITS(4)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .count_enable  (count_enable),
    .rollover_val  (rollover_val),
    .count_out     (count_out),
    .rollover_flag (rollover_flag)
`ifdef FLEX_COUNTER_ROLL_PULSE_EN
    ,
    .rollover_pulse(rollover_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance one edge, then settle past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] exp_cnt, input logic exp_flag);
    chk({tag, ".cnt"}, 32'(count_out), 32'(exp_cnt));
    chk({tag, ".flag"}, 32'(rollover_flag), 32'(exp_flag));
  endtask

  task automatic do_reset();
    n_rst = 1'b1; count_enable = 1'b0; clear = 1'b0;
    tick();
    n_rst = 1'b0;
  endtask

  initial begin
    n_rst = 1'b1; clear = 1'b0; count_enable = 1'b1; rollover_val = 4'd3;

    // Reset wins over enable and holds across both edges and release.
    tick(); chk_state("rst0", 4'd0, 1'b0);
    tick(); chk_state("rst1", 4'd0, 1'b0);
    n_rst = 1'b0; count_enable = 1'b0;
    tick(); chk_state("rst_rel", 4'd0, 1'b0);

    // R=3: three enabled edges then two held edges.
    count_enable = 1'b1;
    tick(); chk_state("r3_e1", 4'd1, 1'b0);
    tick(); chk_state("r3_e2", 4'd2, 1'b0);
    tick(); chk_state("r3_e3", 4'd3, 1'b1);
    count_enable = 1'b0;
    tick(); tick(); chk_state("r3_hold", 4'd3, 1'b1);

    // Partial count and one wrap at R=4.
    do_reset(); rollover_val = 4'd3; count_enable = 1'b1;
    tick(); tick(); chk_state("r3_part", 4'd2, 1'b0);
    do_reset(); rollover_val = 4'd4; count_enable = 1'b1;
    tick(); tick(); tick();
    tick(); chk_state("r4_at4", 4'd4, 1'b1);
    tick(); chk_state("r4_wrap", 4'd1, 1'b0);

    // Discontinuous enable: 0,1,2,2,2,3,4.
    do_reset(); rollover_val = 4'd4; count_enable = 1'b1;
    tick(); chk_state("disc1", 4'd1, 1'b0);
    tick(); chk_state("disc2", 4'd2, 1'b0);
    count_enable = 1'b0;
    tick(); tick(); chk_state("disc_hold", 4'd2, 1'b0);
    count_enable = 1'b1;
    tick(); chk_state("disc3", 4'd3, 1'b0);
    tick(); chk_state("disc4", 4'd4, 1'b1);

    // Terminal value moved onto a held count sets the flag without counting.
    count_enable = 1'b0; rollover_val = 4'd5;
    tick(); chk_state("rv_move_off", 4'd4, 1'b0);
    rollover_val = 4'd4;
    tick(); chk_state("rv_move_on", 4'd4, 1'b1);

    // Clear beats enable; reset beats clear.
    do_reset(); rollover_val = 4'd4; count_enable = 1'b1;
    tick(); chk_state("clr_pre", 4'd1, 1'b0);
    clear = 1'b1;
    tick(); chk_state("clr", 4'd0, 1'b0);
    clear = 1'b0;
    tick(); tick(); chk_state("clr_post", 4'd2, 1'b0);
    clear = 1'b1; n_rst = 1'b1;
    tick(); chk_state("clr_rst", 4'd0, 1'b0);
    clear = 1'b0; n_rst = 1'b0;

    // R=0 from 0: parks at 0 with flag set.
    rollover_val = 4'd0; count_enable = 1'b1;
    tick(); chk_state("r0_a", 4'd0, 1'b1);
    tick(); tick(); chk_state("r0_b", 4'd0, 1'b1);

    // Lowering R below the count forces a natural wrap through 15 -> 0.
    do_reset(); rollover_val = 4'd6; count_enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_state("low_pre", 4'd5, 1'b0);
    rollover_val = 4'd2;
    for (int i = 0; i < 10; i++) tick();
    chk_state("low_15", 4'd15, 1'b0);
    tick(); chk_state("low_0", 4'd0, 1'b0);
    tick(); chk_state("low_1", 4'd1, 1'b0);
    tick(); chk_state("low_2", 4'd2, 1'b1);
    tick(); chk_state("low_roll", 4'd1, 1'b0);

    // R=15: full range then 15 -> 1.
    do_reset(); rollover_val = 4'd15; count_enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk(($sformatf("r15_c%0d", i)), 32'(count_out), 32'(i));
    end
    chk("r15_flag", 32'(rollover_flag), 32'd1);
`ifdef FLEX_COUNTER_ROLL_PULSE_EN
    chk("pulse_pre", 32'(rollover_pulse), 32'd0);
`endif
    tick(); chk_state("r15_roll", 4'd1, 1'b0);
`ifdef FLEX_COUNTER_ROLL_PULSE_EN
    chk("pulse_hi", 32'(rollover_pulse), 32'd1);
    tick();
    chk("pulse_lo", 32'(rollover_pulse), 32'd0);
    chk("pulse_cnt", 32'(count_out), 32'd2);
`endif

    // R=0 from a nonzero count: wraps through 15 to 0 and parks there.
    do_reset(); rollover_val = 4'd0; count_enable = 1'b1;
    tick(); tick(); chk_state("r0w_pre", 4'd0, 1'b1);
    rollover_val = 4'd9;
    for (int i = 0; i < 3; i++) tick();
    chk_state("r0w_3", 4'd3, 1'b0);
    rollover_val = 4'd0;
    for (int i = 0; i < 12; i++) tick();
    chk_state("r0w_15", 4'd15, 1'b0);
    tick(); chk_state("r0w_0", 4'd0, 1'b1);
    tick(); chk_state("r0w_park", 4'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
